// File: rtl/adc_sample_capture.sv
// adc_sample_capture: drives a 12-bit serial ADC (4 leading zeros + 12 data
// bits, MSB first) once per sample period. Each completed word is presented
// with a one-cycle strobe. The block also produces the write/read strobes for
// an echo FIFO, and reads start once DELAY_SAMPLES words have been written.
module adc_sample_capture #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2500,
  parameter int DELAY_SAMPLES = 8000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sdata,
  output logic        sclk,
  output logic        cs_n,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        wr_en,
  output logic        rd_en
);

  localparam int PER_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FILL_W = (DELAY_SAMPLES > 0) ? $clog2(DELAY_SAMPLES + 1) : 1;

  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DELAY_SAMPLES);

  // A frame takes 32*CLK_DIV+2 cycles from tick to return to IDLE; a shorter
  // period would drop ticks and break the fixed sample rate.
  if (SAMPLE_PERIOD < 32 * CLK_DIV + 3) begin : g_bad_period
    $error("adc_sample_capture: SAMPLE_PERIOD must be >= 32*CLK_DIV+3");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("adc_sample_capture: CLK_DIV must be >= 1");
  end
  if (DELAY_SAMPLES < 1) begin : g_bad_delay
    $error("adc_sample_capture: DELAY_SAMPLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [PER_W-1:0]  r_per_cnt;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_bit;
  logic [FILL_W-1:0] r_fill;
  logic              r_sclk;
  logic              r_cs_n;
  logic [11:0]       r_sample;
  logic              r_valid;
  logic              r_wr;
  logic              r_rd;
  // Only the low 12 bits of the 16-bit frame are kept; the four leading
  // bits shift out of the top and are never looked at.
  logic [11:0]       r_shift;

  logic              w_tick;
  logic              w_sclk_rise;

  assign w_tick      = (r_per_cnt == PER_LAST);
  assign w_sclk_rise = (r_state == S_CONV) && (r_div == DIV_LAST) && !r_sclk;

  // Free-running sample-period counter; its wrap cycle is the conversion tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per_cnt <= '0;
    end else if (w_tick) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  // Capture serial data MSB first on every sclk 0->1 transition.
  always_ff @(posedge clk) begin
    if (w_sclk_rise) begin
      r_shift <= {r_shift[10:0], sdata};
    end
  end

  // Conversion FSM: frames the ADC transfer, emits strobes, tracks FIFO fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_fill   <= '0;
      r_sclk   <= 1'b1;
      r_cs_n   <= 1'b1;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cs_n <= 1'b1;
          r_sclk <= 1'b1;
          r_div  <= '0;
          r_bit  <= '0;
          // Disabling restarts the echo delay from empty.
          if (!en) begin
            r_fill <= '0;
          end
          if (w_tick && en) begin
            r_state <= S_CONV;
            r_cs_n  <= 1'b0;
          end
        end
        S_CONV: begin
          if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (!r_sclk) begin
              if (r_bit == 4'd15) begin
                r_bit   <= '0;
                r_state <= S_DONE;
                r_cs_n  <= 1'b1;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        S_DONE: begin
          r_sample <= r_shift;
          r_valid  <= 1'b1;
          r_wr     <= 1'b1;
          r_rd     <= (r_fill == FILL_MAX);
          if (r_fill != FILL_MAX) begin
            r_fill <= r_fill + 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sclk         = r_sclk;
  assign cs_n         = r_cs_n;
  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign wr_en        = r_wr;
  assign rd_en        = r_rd;

endmodule
